// File: rtl/subservient_mem_arbiter.sv
// Three-master (ibus / dbus / dbg) arbiter onto a single memory port; one transfer at a time.
// Define SUBSERVIENT_MEM_ARBITER_TIMEOUT_EN to force-terminate transfers after TIMEOUT BUSY cycles.
module subservient_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_debug_mode,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_stb,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_stb,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic [31:0] i_dbg_adr,
  input  logic [31:0] i_dbg_dat,
  input  logic [3:0]  i_dbg_sel,
  input  logic        i_dbg_we,
  input  logic        i_dbg_stb,
  output logic [31:0] o_dbg_rdt,
  output logic        o_dbg_ack,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  output logic [3:0]  o_mem_sel,
  output logic        o_mem_we,
  output logic        o_mem_stb,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("subservient_mem_arbiter: TIMEOUT must be in 2..65535");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IBUS = 2'd1;
  localparam logic [1:0] GNT_DBUS = 2'd2;
  localparam logic [1:0] GNT_DBG  = 2'd3;

  state_t      state, state_nxt;
  logic [1:0]  grant, grant_nxt;
  logic        last_dbus, last_dbus_nxt;

  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_stb;
  logic        busy, live, mem_done, timeout_hit, ack_any;
  logic        ibus_req, dbus_req, dbg_req;

  // Request view of the currently granted master
  always_comb begin
    m_adr = '0;
    m_dat = '0;
    m_sel = '0;
    m_we  = 1'b0;
    m_stb = 1'b0;
    case (grant)
      GNT_IBUS: begin
        m_adr = i_ibus_adr;
        m_sel = 4'hF;
        m_stb = i_ibus_stb;
      end
      GNT_DBUS: begin
        m_adr = i_dbus_adr;
        m_dat = i_dbus_dat;
        m_sel = i_dbus_sel;
        m_we  = i_dbus_we;
        m_stb = i_dbus_stb;
      end
      GNT_DBG: begin
        m_adr = i_dbg_adr;
        m_dat = i_dbg_dat;
        m_sel = i_dbg_sel;
        m_we  = i_dbg_we;
        m_stb = i_dbg_stb;
      end
      default: ;
    endcase
  end

  assign busy     = (state == BUSY);
  assign live     = busy && m_stb;
  assign mem_done = live && i_mem_ack;

`ifdef SUBSERVIENT_MEM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] busy_cnt;

  // Counts BUSY cycles already completed; zero on the first cycle of every grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      busy_cnt <= '0;
    else if (busy && state_nxt == BUSY)
      busy_cnt <= busy_cnt + 16'd1;
    else
      busy_cnt <= '0;
  end

  assign timeout_hit = live && !i_mem_ack && (busy_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign ack_any  = mem_done || timeout_hit;
  assign ibus_req = i_ibus_stb && !i_debug_mode;
  assign dbus_req = i_dbus_stb;
  assign dbg_req  = i_dbg_stb && i_debug_mode;

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    last_dbus_nxt = last_dbus;
    case (state)
      IDLE: begin
        if (dbg_req) begin
          state_nxt = BUSY;
          grant_nxt = GNT_DBG;
        end else if (ibus_req && dbus_req) begin
          state_nxt = BUSY;
          grant_nxt = last_dbus ? GNT_IBUS : GNT_DBUS;
        end else if (ibus_req) begin
          state_nxt = BUSY;
          grant_nxt = GNT_IBUS;
        end else if (dbus_req) begin
          state_nxt = BUSY;
          grant_nxt = GNT_DBUS;
        end
      end
      BUSY: begin
        if (!m_stb || ack_any) begin
          state_nxt = IDLE;
          grant_nxt = GNT_NONE;
        end
        // Only a real memory ack moves the ibus/dbus fairness pointer
        if (mem_done && grant != GNT_DBG)
          last_dbus_nxt = (grant == GNT_DBUS);
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      last_dbus <= 1'b1;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last_dbus <= last_dbus_nxt;
    end
  end

  assign o_grant   = grant;
  assign o_timeout = timeout_hit;

  assign o_mem_adr = busy ? m_adr : '0;
  assign o_mem_dat = busy ? m_dat : '0;
  assign o_mem_sel = busy ? m_sel : '0;
  assign o_mem_we  = busy && m_we;
  assign o_mem_stb = live && !timeout_hit;

  // A forced termination acks with zero data
  assign o_ibus_ack = ack_any && (grant == GNT_IBUS);
  assign o_dbus_ack = ack_any && (grant == GNT_DBUS);
  assign o_dbg_ack  = ack_any && (grant == GNT_DBG);
  assign o_ibus_rdt = (mem_done && grant == GNT_IBUS) ? i_mem_rdt : '0;
  assign o_dbus_rdt = (mem_done && grant == GNT_DBUS) ? i_mem_rdt : '0;
  assign o_dbg_rdt  = (mem_done && grant == GNT_DBG)  ? i_mem_rdt : '0;

endmodule

// File: doc/subservient_mem_arbiter.md
SUBSERVIENT_MEM_ARBITER -- requirements
Module: subservient_mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum BUSY cycles before forced termination (range 2..65535).
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all flops on rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port i_debug_mode, input, 1; when high, ibus requests are masked.
REQ-005 The block SHALL have ibus ports: i_ibus_adr in 32, i_ibus_stb in 1, o_ibus_rdt out 32, o_ibus_ack out 1.
REQ-006 The block SHALL have dbus ports: i_dbus_adr in 32, i_dbus_dat in 32, i_dbus_sel in 4, i_dbus_we in 1, i_dbus_stb in 1, o_dbus_rdt out 32, o_dbus_ack out 1.
REQ-007 The block SHALL have dbg ports with the same names, directions and widths as dbus, using prefix dbg.
REQ-008 The block SHALL have memory ports: o_mem_adr out 32, o_mem_dat out 32, o_mem_sel out 4, o_mem_we out 1, o_mem_stb out 1, i_mem_rdt in 32, i_mem_ack in 1.
REQ-009 The block SHALL have o_grant, out, 2: the current owner, where 0 = none, 1 = ibus, 2 = dbus, 3 = dbg.
REQ-010 The block SHALL have o_timeout, out, 1: a one-cycle pulse on forced termination.

Function
REQ-011 The block SHALL have two states: IDLE (o_grant=0) and BUSY (o_grant nonzero, registered).
REQ-012 In IDLE, when any unmasked stb is high, the block SHALL register the winner and enter BUSY on the next edge; arbitration latency is 1 cycle.
REQ-013 Priority SHALL be: dbg (only when i_debug_mode=1) strictly highest; between ibus and dbus, round-robin favouring the one not served last (last_served resets to dbus, so ibus wins the first tie).
REQ-014 When i_debug_mode=0, dbg stb SHALL be ignored; when i_debug_mode=1, ibus stb SHALL be ignored.
REQ-015 In BUSY, o_mem_adr/dat/sel/we/stb SHALL be driven combinationally from the granted master (ibus: dat=0, sel=4'hF, we=0); in IDLE they SHALL be 0.
REQ-016 In BUSY, i_mem_ack=1 SHALL produce, in the same cycle, ack=1 and rdt=i_mem_rdt to the granted master only, return to IDLE, and update last_served (ibus/dbus grants only).
REQ-017 Non-granted acks SHALL be 0, and all o_*_rdt SHALL be 0 when the corresponding ack is 0.
REQ-018 If the granted master drops stb while BUSY, the block SHALL return to IDLE without acking and without updating last_served.
REQ-019 i_mem_ack while in IDLE SHALL be ignored.
REQ-020 Back-to-back operation: a request pending at ack time SHALL be arbitrated in IDLE the following cycle, giving a minimum of 1 IDLE cycle between grants.

Reset
REQ-021 While i_rst_n=0, the state SHALL be IDLE, o_grant=0, last_served=dbus, the timeout counter 0, and all outputs 0, asynchronously.
REQ-022 Reset asserted mid-transfer SHALL abandon the transfer with no ack; the first grant after release SHALL follow REQ-013.

Configuration
REQ-023 With macro SUBSERVIENT_MEM_ARBITER_TIMEOUT_EN defined, a 16-bit counter SHALL count BUSY cycles; when it reaches TIMEOUT without ack, the block SHALL ack the master with rdt=32'h0, pulse o_timeout, drop o_mem_stb and enter IDLE; the counter SHALL clear on every IDLE entry.
REQ-024 With the macro undefined, the block SHALL contain no counter, o_timeout SHALL be tied to 0, and BUSY SHALL persist until ack or stb drop.

Verification
REQ-025 The bench SHALL check: ibus and dbus stb asserted together from reset, mem acks after 2 cycles -> ibus granted first, o_grant=1, ibus ack with rdt=i_mem_rdt; then dbus granted (o_grant=2) after 1 IDLE cycle.
REQ-026 The bench SHALL check: i_debug_mode=1 with dbg, ibus and dbus stb all high -> dbg granted; after its ack, dbus granted; ibus is never granted while the mode is high.
REQ-027 The bench SHALL check: dbus write adr=0x00000010, dat=0xA5A5A5A5, sel=4'h3 -> o_mem_* equal these values with we=1 during BUSY; o_ibus_ack stays 0.
REQ-028 The bench SHALL check: dbus drops stb 3 cycles into BUSY with no ack -> IDLE next cycle, no acks, and the next ibus/dbus tie still favours the same side.
REQ-029 The bench SHALL check, with TIMEOUT_EN and TIMEOUT=4 and mem never acking -> master ack with rdt=0 and o_timeout high for 1 cycle after 4 BUSY cycles; without the macro, BUSY holds for 100+ cycles.
REQ-030 The bench SHALL check: i_rst_n pulled low mid-BUSY -> outputs 0 immediately and o_grant=0; after release, a tie grants ibus.
